// File: rtl/seg_reader_pkg.sv
// Shared types and constants for the two-digit 7-segment display reader.
// Segment bits are G..A in bits 6..0, DP in bit 7, digit enable (active low) in bit 8.
package seg_reader_pkg;

  // Bit position of the active-low digit enable; a set bit means the digit is blank.
  localparam int unsigned SegBlankBit = 8;
  localparam int unsigned SegDpBit    = 7;

  localparam logic [6:0] SegPat0 = 7'h3F;
  localparam logic [6:0] SegPat1 = 7'h06;
  localparam logic [6:0] SegPat2 = 7'h5B;
  localparam logic [6:0] SegPat3 = 7'h4F;
  localparam logic [6:0] SegPat4 = 7'h66;
  localparam logic [6:0] SegPat5 = 7'h6D;
  localparam logic [6:0] SegPat6 = 7'h7D;
  localparam logic [6:0] SegPat7 = 7'h07;
  localparam logic [6:0] SegPat8 = 7'h7F;
  localparam logic [6:0] SegPat9 = 7'h6F;

  typedef logic [8:0] seg_code_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } fsm_state_t;

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational decode of one 9-bit 7-segment digit code into a BCD digit.
// legal_o is set only for an enabled digit showing one of the ten patterns;
// a blank digit reports blank_o=1, legal_o=0, digit_o=0.
module seg7_digit_decode
  import seg_reader_pkg::*;
(
  input  seg_code_t  code_i,
  output logic [3:0] digit_o,
  output logic       blank_o,
  output logic       legal_o
);

  // The decimal point carries no digit information.
  logic unused_dp;
  assign unused_dp = code_i[SegDpBit];

  // Pattern match against the ten legal glyphs.
  always_comb begin
    digit_o = 4'd0;
    legal_o = 1'b0;
    blank_o = code_i[SegBlankBit];
    if (!blank_o) begin
      legal_o = 1'b1;
      case (code_i[6:0])
        SegPat0: digit_o = 4'd0;
        SegPat1: digit_o = 4'd1;
        SegPat2: digit_o = 4'd2;
        SegPat3: digit_o = 4'd3;
        SegPat4: digit_o = 4'd4;
        SegPat5: digit_o = 4'd5;
        SegPat6: digit_o = 4'd6;
        SegPat7: digit_o = 4'd7;
        SegPat8: digit_o = 4'd8;
        SegPat9: digit_o = 4'd9;
        default: legal_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/seg_pair_reader.sv
// Receiver for the two-digit 7-segment timer display. Registers the raw digit
// codes, debounces them with a stability counter, decodes accepted values and
// checks that each accepted change is a single legal step of the timer.
// Optional cycle-period measurement is built when SEG_PAIR_READER_PERIOD_EN is defined;
// otherwise period_o is tied to zero.
module seg_pair_reader
  import seg_reader_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned MODULUS       = 60,
  parameter bit          COUNT_DOWN    = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [8:0]  segment_led_1,
  input  logic [8:0]  segment_led_2,
  output logic [6:0]  value_o,
  output logic        valid_o,
  output logic        update_o,
  output logic        step_err_o,
  output logic        code_err_o,
  output logic [31:0] period_o
);

  localparam logic [7:0] StableCnt = 8'(STABLE_CYCLES);
  localparam logic [6:0] ModVal    = 7'(MODULUS);
  localparam logic [6:0] MaxVal    = 7'(MODULUS - 1);

  logic [17:0] in_q, in_d;
  logic [17:0] prev_q, prev_d;
  logic [7:0]  cnt_q, cnt_d;
  fsm_state_t  state_q, state_d;
  logic [6:0]  value_q, value_d;
  logic        valid_q, valid_d;
  logic        update_q, update_d;
  logic        step_err_q, step_err_d;
  logic        code_err_q, code_err_d;

  logic        changed;
  logic        reached;
  logic        code_evt;
  logic [3:0]  tens_digit, units_digit;
  logic        tens_blank, units_blank;
  logic        tens_legal, units_legal;
  logic [6:0]  dec_value;
  logic        dec_ok;
  logic [6:0]  succ_value;

  seg7_digit_decode u_tens (
    .code_i  (in_q[17:9]),
    .digit_o (tens_digit),
    .blank_o (tens_blank),
    .legal_o (tens_legal)
  );

  seg7_digit_decode u_units (
    .code_i  (in_q[8:0]),
    .digit_o (units_digit),
    .blank_o (units_blank),
    .legal_o (units_legal)
  );

  // Input capture and stability filter; the counter saturates so a held display stays quiet.
  always_comb begin
    in_d    = {segment_led_1, segment_led_2};
    prev_d  = in_q;
    changed = (in_q != prev_q);
    if (changed) begin
      cnt_d = 8'd1;
    end else if (cnt_q < StableCnt) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    // Fires once per run of identical samples; the changed term covers STABLE_CYCLES == 1.
    reached = (cnt_d == StableCnt) && (changed || (cnt_q != StableCnt));
  end

  // Pair decode: blank tens reads as 0, blank units or out-of-range values are illegal.
  always_comb begin
    dec_value = ({3'b000, tens_digit} * 7'd10) + {3'b000, units_digit};
    dec_ok    = (tens_blank || tens_legal) && !units_blank && units_legal &&
                (dec_value < ModVal);
    if (COUNT_DOWN) begin
      succ_value = (value_q == 7'd0) ? MaxVal : value_q - 7'd1;
    end else begin
      succ_value = (value_q == MaxVal) ? 7'd0 : value_q + 7'd1;
    end
  end

  // Acceptance FSM: next state and registered output pulses.
  always_comb begin
    state_d    = state_q;
    value_d    = value_q;
    valid_d    = valid_q;
    update_d   = 1'b0;
    step_err_d = 1'b0;
    code_err_d = code_err_q;
    code_evt   = 1'b0;
    case (state_q)
      IDLE: begin
        if (reached) begin
          if (dec_ok) begin
            // First value after reset or a code error: resync without a step check.
            value_d  = dec_value;
            valid_d  = 1'b1;
            update_d = 1'b1;
            state_d  = LOCKED;
          end else begin
            code_err_d = 1'b1;
            code_evt   = 1'b1;
          end
        end
      end
      SETTLE, LOCKED: begin
        if (reached) begin
          if (!dec_ok) begin
            code_err_d = 1'b1;
            code_evt   = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = LOCKED;
            // Settling back onto the current value is silent.
            if (dec_value != value_q) begin
              value_d    = dec_value;
              update_d   = 1'b1;
              step_err_d = (dec_value != succ_value);
            end
          end
        end else if (changed) begin
          state_d = SETTLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Core state registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      in_q       <= '0;
      prev_q     <= '0;
      cnt_q      <= '0;
      state_q    <= IDLE;
      value_q    <= '0;
      valid_q    <= 1'b0;
      update_q   <= 1'b0;
      step_err_q <= 1'b0;
      code_err_q <= 1'b0;
    end else begin
      in_q       <= in_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      value_q    <= value_d;
      valid_q    <= valid_d;
      update_q   <= update_d;
      step_err_q <= step_err_d;
      code_err_q <= code_err_d;
    end
  end

  assign value_o    = value_q;
  assign valid_o    = valid_q;
  assign update_o   = update_q;
  assign step_err_o = step_err_q;
  assign code_err_o = code_err_q;

`ifdef SEG_PAIR_READER_PERIOD_EN
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] period_q, period_d;
  logic        have_prev_q, have_prev_d;
  logic [31:0] per_cnt_inc;

  // Cycle counter restarts on each update; period latches the gap between updates.
  always_comb begin
    per_cnt_inc = (per_cnt_q == 32'hFFFF_FFFF) ? per_cnt_q : per_cnt_q + 32'd1;
    per_cnt_d   = per_cnt_inc;
    period_d    = period_q;
    have_prev_d = have_prev_q;
    if (code_evt) begin
      per_cnt_d   = '0;
      period_d    = '0;
      have_prev_d = 1'b0;
    end else if (update_d) begin
      if (have_prev_q) begin
        period_d = per_cnt_inc;
      end
      per_cnt_d   = '0;
      have_prev_d = 1'b1;
    end
  end

  // Period measurement registers.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      per_cnt_q   <= '0;
      period_q    <= '0;
      have_prev_q <= 1'b0;
    end else begin
      per_cnt_q   <= per_cnt_d;
      period_q    <= period_d;
      have_prev_q <= have_prev_d;
    end
  end

  assign period_o = period_q;
`else
  logic unused_code_evt;
  assign unused_code_evt = code_evt;
  assign period_o = 32'd0;
`endif

endmodule

// File: tb/tb_seg_pair_reader.sv
// Randomized scoreboard bench for seg_pair_reader. Stimulus is a sequence of
// display runs (pattern, duration); the model turns each run long enough to be
// accepted into an expected event with its arrival edge, and a monitor compares.
module tb_seg_pair_reader;

  localparam int unsigned STABLE = 4;
  localparam int unsigned MOD    = 60;
  localparam bit          DOWN   = 1'b1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [8:0]  led1 = 9'h000;
  logic [8:0]  led2 = 9'h000;
  logic [6:0]  value_o;
  logic        valid_o, update_o, step_err_o, code_err_o;
  logic [31:0] period_o;

  seg_pair_reader #(
    .STABLE_CYCLES (STABLE),
    .MODULUS       (MOD),
    .COUNT_DOWN    (DOWN)
  ) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .segment_led_1 (led1),
    .segment_led_2 (led2),
    .value_o       (value_o),
    .valid_o       (valid_o),
    .update_o      (update_o),
    .step_err_o    (step_err_o),
    .code_err_o    (code_err_o),
    .period_o      (period_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          is_code;
    logic [6:0]  value;
    bit          step_err;
    int unsigned edge_n;
    logic [31:0] period;
  } ev_t;

  ev_t exp_q[$];
  int  passed = 0;
  int  total  = 0;

  // Model state
  bit          m_synced, m_valid, m_code, m_have_prev;
  logic [6:0]  m_val;
  int unsigned m_last_edge;
  logic [31:0] m_period;
  logic [17:0] last_p;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [6:0] seg(input int d);
    case (d)
      0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
      4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
      8: return 7'h7F; default: return 7'h6F;
    endcase
  endfunction

  function automatic int dig(input logic [6:0] s);
    for (int d = 0; d < 10; d++) if (seg(d) == s) return d;
    return -1;
  endfunction

  function automatic logic [17:0] enc(input int v, input bit blank_tens);
    logic [8:0] t, u;
    t = (blank_tens && v < 10) ? 9'h100 : {2'b00, seg(v / 10)};
    u = {2'b00, seg(v % 10)};
    return {t, u};
  endfunction

  function automatic int succ(input int v);
    if (DOWN) return (v == 0) ? MOD - 1 : v - 1;
    return (v == MOD - 1) ? 0 : v + 1;
  endfunction

  // Reference decode of a display pair: returns -1 when not a legal count.
  function automatic int decode(input logic [17:0] p);
    int t, u;
    t = p[17] ? 0 : dig(p[15:9]);
    u = p[8] ? -1 : dig(p[6:0]);
    if (t < 0 || u < 0 || (t * 10 + u) >= MOD) return -1;
    return t * 10 + u;
  endfunction

  // Drive one run; called at posedge+1, so the first sample is edge cyc+1.
  task automatic run(input logic [17:0] p, input int unsigned dur);
    ev_t e;
    int  v;
    if (dur >= STABLE) begin
      v = decode(p);
      e.edge_n = cyc + 1 + STABLE;
      e.is_code = (v < 0);
      e.value = 7'(v);
      e.step_err = 1'b0;
      e.period = 32'd0;
      if (v < 0) begin
        if (!m_code) exp_q.push_back(e);
        m_code = 1'b1;
        m_synced = 1'b0;
        m_have_prev = 1'b0;
        m_period = 32'd0;
      end else if (!m_synced || 7'(v) != m_val) begin
        e.step_err = m_synced && (v != succ(int'(m_val)));
        if (m_have_prev) m_period = e.edge_n - m_last_edge;
        m_last_edge = e.edge_n;
        m_have_prev = 1'b1;
`ifdef SEG_PAIR_READER_PERIOD_EN
        e.period = m_period;
`endif
        exp_q.push_back(e);
        m_synced = 1'b1;
        m_valid = 1'b1;
        m_val = 7'(v);
      end
    end
    {led1, led2} = p;
    last_p = p;
    repeat (dur) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_value"}, 32'(value_o), 0);
    check({tag, "_valid"}, 32'(valid_o), 0);
    check({tag, "_update"}, 32'(update_o), 0);
    check({tag, "_step_err"}, 32'(step_err_o), 0);
    check({tag, "_code_err"}, 32'(code_err_o), 0);
    check({tag, "_period"}, period_o, 0);
  endtask

  // Asynchronous reset; entered and left at posedge+1.
  task automatic do_reset();
    check("queue_empty_before_reset", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset");
    exp_q.delete();
    m_synced = 0; m_valid = 0; m_code = 0; m_have_prev = 0;
    m_val = '0; m_period = '0; m_last_edge = 0; last_p = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pop an expectation whenever the DUT reports an event.
  logic code_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      code_prev <= 1'b0;
    end else begin
      if (step_err_o && !update_o) check("step_err_without_update", 32'(update_o), 1);
      if (update_o || (code_err_o && !code_prev)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_event_pending", 0, 1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("event_edge", cyc, e.edge_n);
          if (e.is_code) begin
            check("code_err_rise", 32'(code_err_o), 1);
            check("code_no_update", 32'(update_o), 0);
          end else begin
            check("update_pulse", 32'(update_o), 1);
            check("update_value", 32'(value_o), 32'(e.value));
            check("update_step_err", 32'(step_err_o), 32'(e.step_err));
            check("update_valid", 32'(valid_o), 1);
            check("update_period", period_o, e.period);
          end
        end
      end
      code_prev <= code_err_o;
    end
  end

  initial begin
    logic [17:0] p;
    int          r, v;
    int unsigned dur;

    {led1, led2} = enc(60, 1'b0);
    @(posedge clk);
    #1;
    do_reset();

    // Out-of-range stable value right after reset
    run(enc(60, 1'b0), 10);
    check("sixty_code_err", 32'(code_err_o), 1);
    check("sixty_valid", 32'(valid_o), 0);
    do_reset();

    // Normal countdown
    run(enc(59, 1'b0), 20);
    run(enc(58, 1'b0), 20);
    run(enc(57, 1'b0), 20);
    // Wrap then a bad step
    run(enc(1, 1'b1), 10);
    run(enc(0, 1'b1), 10);
    run(enc(59, 1'b0), 10);
    run(enc(57, 1'b0), 10);
    check("after_bad_step_value", 32'(value_o), 57);
    // Glitch rejection
    run(enc(42, 1'b0), 10);
    run(enc(43, 1'b0), 2);
    run(enc(42, 1'b0), 10);
    check("glitch_value_held", 32'(value_o), 42);
    // Undecodable units, then resync
    run({9'(seg(3)), 9'h000}, 10);
    check("units_blank_code_err", 32'(code_err_o), 1);
    check("units_blank_value_held", 32'(value_o), 42);
    check("units_blank_valid_held", 32'(valid_o), 1);
    run(enc(30, 1'b0), 10);
    check("resync_value", 32'(value_o), 30);
    do_reset();

    // Randomized runs
    for (int i = 0; i < 150; i++) begin
      do begin
        r = int'($urandom_range(0, 19));
        if (r == 0) p = enc(int'($urandom_range(60, 99)), 1'b0);
        else if (r == 1) p = {9'(seg(int'($urandom_range(0, 5)))), 9'h100};
        else if (r == 2) p = {9'(seg(int'($urandom_range(0, 5)))), 2'b00, 7'($urandom)};
        else if (r <= 5 || !m_synced) p = enc(int'($urandom_range(0, MOD - 1)), 1'($urandom));
        else begin
          v = succ(int'(m_val));
          p = enc(v, 1'($urandom));
          if (r == 6) p[7] = 1'b1;
        end
      end while (p == last_p);
      dur = ($urandom_range(0, 3) == 0) ? $urandom_range(1, STABLE - 1)
                                        : $urandom_range(STABLE, STABLE + 8);
      run(p, dur);
    end

    // Drain and compare final state
    run(last_p ^ 18'h00080, STABLE + 4);
    repeat (3) @(posedge clk);
    #1;
    check("final_queue_empty", exp_q.size(), 0);
    check("final_value", 32'(value_o), 32'(m_val));
    check("final_valid", 32'(valid_o), 32'(m_valid));
    check("final_code_err", 32'(code_err_o), 32'(m_code));

    // Asynchronous reset in the middle of a cycle
    {led1, led2} = enc(int'($urandom_range(0, MOD - 1)), 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrun_reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
